// File: rtl/icb_dma_master_pkg.sv
// Shared types and constants for the ICB DMA master: FSM state encoding, write mask, default buffer width.
// Pure definitions, no logic and no flow control.
package icb_dma_master_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_FETCH = 3'd1,
      ST_LOAD  = 3'd2,
      ST_CMD   = 3'd3,
      ST_RSP   = 3'd4,
      ST_FIN   = 3'd5
   } state_e;

   localparam logic [3:0] ICB_WMASK_FULL = 4'hF;
   localparam int         BUF_AW_DEFAULT = 13;

endpackage

// File: rtl/icb_dma_master.sv
// Single-outstanding ICB DMA master copying words between a local SRAM buffer and ICB; 4 cycles/word writing, 2 reading at zero wait.
// ICB command/response stalls simply hold the FSM in CMD/RSP with command fields frozen.
module icb_dma_master
   import icb_dma_master_pkg::*;
#(
   parameter int BUF_AW = BUF_AW_DEFAULT
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [31:0]       cfg_base,
   input  logic [BUF_AW:0]   cfg_len,
   input  logic              cfg_dir,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic              buf_rd_en,
   output logic [BUF_AW-1:0] buf_rd_addr,
   input  logic [31:0]       buf_rd_data,
   output logic              buf_wr_en,
   output logic [BUF_AW-1:0] buf_wr_addr,
   output logic [31:0]       buf_wr_data,
   output logic              icb_cmd_valid,
   input  logic              icb_cmd_ready,
   output logic              icb_cmd_read,
   output logic [31:0]       icb_cmd_addr,
   output logic [31:0]       icb_cmd_wdata,
   output logic [3:0]        icb_cmd_wmask,
   input  logic              icb_rsp_valid,
   output logic              icb_rsp_ready,
   input  logic [31:0]       icb_rsp_rdata,
   input  logic              icb_rsp_err
);

   localparam logic [BUF_AW:0] IDX_ONE = {{BUF_AW{1'b0}}, 1'b1};

   state_e            state_q, state_d;
   logic [31:0]       base_q, base_d;
   logic [BUF_AW:0]   len_q, len_d;
   logic [BUF_AW:0]   idx_q, idx_d;
   logic [BUF_AW:0]   idx_inc;
   logic              dir_q, dir_d;
   logic              err_q, err_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [31:0]       cmd_addr_q, cmd_addr_d;
   logic              cmd_vld_q, cmd_vld_d;
   logic              rsp_rdy_q, rsp_rdy_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              rd_en_q, rd_en_d;
   logic [BUF_AW-1:0] rd_addr_q, rd_addr_d;

   assign idx_inc = idx_q + IDX_ONE;

   always_comb begin
      state_d = state_q;
      base_d  = base_q;
      len_d   = len_q;
      idx_d   = idx_q;
      dir_d   = dir_q;
      err_d   = err_q;
      wdata_d = wdata_q;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               base_d = cfg_base & 32'hFFFF_FFFC;
               len_d  = cfg_len;
               dir_d  = cfg_dir;
               err_d  = 1'b0;
               idx_d  = '0;
               if (cfg_len == '0)
                  state_d = ST_FIN;
               else if (cfg_dir)
                  state_d = ST_CMD;
               else
                  state_d = ST_FETCH;
            end
         end
         ST_FETCH: state_d = ST_LOAD;
         ST_LOAD: begin
            wdata_d = buf_rd_data;
            state_d = ST_CMD;
         end
         ST_CMD: begin
            if (icb_cmd_ready)
               state_d = ST_RSP;
         end
         ST_RSP: begin
            if (icb_rsp_valid) begin
               if (icb_rsp_err) begin
                  err_d   = 1'b1;
                  state_d = ST_FIN;
               end else begin
                  idx_d = idx_inc;
                  if (idx_inc == len_q)
                     state_d = ST_FIN;
                  else if (dir_q)
                     state_d = ST_CMD;
                  else
                     state_d = ST_FETCH;
               end
            end
         end
         ST_FIN:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase

      // Outputs are decoded from the next state so they line up with the registered state.
      busy_d     = (state_d == ST_FETCH) || (state_d == ST_LOAD) ||
                   (state_d == ST_CMD)   || (state_d == ST_RSP);
      done_d     = (state_d == ST_FIN);
      rd_en_d    = (state_d == ST_FETCH);
      rd_addr_d  = (state_d == ST_FETCH) ? idx_d[BUF_AW-1:0] : rd_addr_q;
      cmd_vld_d  = (state_d == ST_CMD);
      cmd_addr_d = (state_d == ST_CMD) ? base_d + 32'({idx_d, 2'b00}) : cmd_addr_q;
      rsp_rdy_d  = (state_d == ST_RSP);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         base_q     <= '0;
         len_q      <= '0;
         idx_q      <= '0;
         dir_q      <= 1'b0;
         err_q      <= 1'b0;
         wdata_q    <= '0;
         cmd_addr_q <= '0;
         cmd_vld_q  <= 1'b0;
         rsp_rdy_q  <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         rd_en_q    <= 1'b0;
         rd_addr_q  <= '0;
      end else begin
         state_q    <= state_d;
         base_q     <= base_d;
         len_q      <= len_d;
         idx_q      <= idx_d;
         dir_q      <= dir_d;
         err_q      <= err_d;
         wdata_q    <= wdata_d;
         cmd_addr_q <= cmd_addr_d;
         cmd_vld_q  <= cmd_vld_d;
         rsp_rdy_q  <= rsp_rdy_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         rd_en_q    <= rd_en_d;
         rd_addr_q  <= rd_addr_d;
      end
   end

   // Read data lands in the buffer in the very cycle the response is accepted.
   assign buf_wr_en   = !rst && (state_q == ST_RSP) && icb_rsp_valid && !icb_rsp_err && dir_q;
   assign buf_wr_addr = buf_wr_en ? idx_q[BUF_AW-1:0] : '0;
   assign buf_wr_data = buf_wr_en ? icb_rsp_rdata : '0;

   assign busy          = busy_q;
   assign done          = done_q;
   assign err           = err_q;
   assign buf_rd_en     = rd_en_q;
   assign buf_rd_addr   = rd_addr_q;
   assign icb_cmd_valid = cmd_vld_q;
   assign icb_cmd_read  = dir_q;
   assign icb_cmd_addr  = cmd_addr_q;
   assign icb_cmd_wdata = wdata_q;
   assign icb_cmd_wmask = ICB_WMASK_FULL;
   assign icb_rsp_ready = rsp_rdy_q;

endmodule

// File: tb/tb_icb_dma_master.sv
// Scoreboard bench for icb_dma_master: directed transfers push expected ICB commands, buffer writes
// and done pulses; a negedge monitor pops and compares as the DUT presents them.
module tb_icb_dma_master;

   localparam int BUF_AW = 13;

   typedef struct { logic [31:0] addr; logic rd; logic [31:0] wdata; } cmd_t;
   typedef struct { int addr; logic [31:0] data; } wr_t;
   typedef struct { logic err; int cyc; } done_t;

   logic              clk = 1'b0;
   logic              rst, start, cfg_dir;
   logic [31:0]       cfg_base;
   logic [BUF_AW:0]   cfg_len;
   logic              busy, done, err;
   logic              buf_rd_en, buf_wr_en;
   logic [BUF_AW-1:0] buf_rd_addr, buf_wr_addr;
   logic [31:0]       buf_rd_data, buf_wr_data;
   logic              icb_cmd_valid, icb_cmd_ready, icb_cmd_read;
   logic [31:0]       icb_cmd_addr, icb_cmd_wdata;
   logic [3:0]        icb_cmd_wmask;
   logic              icb_rsp_valid, icb_rsp_ready, icb_rsp_err;
   logic [31:0]       icb_rsp_rdata;

   int n_chk = 0, n_fail = 0, cyc = 0, hs_cnt = 0, done_cnt = 0;
   cmd_t  exp_cmd_q[$];
   wr_t   exp_wr_q[$];
   done_t exp_done_q[$];

   logic [31:0] mem [0:7];
   logic [31:0] rd_data [0:7];
   int   cmd_stall = 0, rsp_delay = 0, err_word = -1;
   logic flush_req = 1'b0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   icb_dma_master #(.BUF_AW(BUF_AW)) dut (
      .clk(clk), .rst(rst), .start(start), .cfg_base(cfg_base), .cfg_len(cfg_len), .cfg_dir(cfg_dir),
      .busy(busy), .done(done), .err(err),
      .buf_rd_en(buf_rd_en), .buf_rd_addr(buf_rd_addr), .buf_rd_data(buf_rd_data),
      .buf_wr_en(buf_wr_en), .buf_wr_addr(buf_wr_addr), .buf_wr_data(buf_wr_data),
      .icb_cmd_valid(icb_cmd_valid), .icb_cmd_ready(icb_cmd_ready), .icb_cmd_read(icb_cmd_read),
      .icb_cmd_addr(icb_cmd_addr), .icb_cmd_wdata(icb_cmd_wdata), .icb_cmd_wmask(icb_cmd_wmask),
      .icb_rsp_valid(icb_rsp_valid), .icb_rsp_ready(icb_rsp_ready), .icb_rsp_rdata(icb_rsp_rdata),
      .icb_rsp_err(icb_rsp_err)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, want 0x%08h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic push_cmd(input logic [31:0] a, input logic r, input logic [31:0] wd);
      cmd_t c;
      c.addr = a; c.rd = r; c.wdata = wd;
      exp_cmd_q.push_back(c);
   endtask

   task automatic push_wr(input int a, input logic [31:0] d);
      wr_t w;
      w.addr = a; w.data = d;
      exp_wr_q.push_back(w);
   endtask

   // Start is driven during cycle S; done (if expected) must appear in cycle S+done_off.
   task automatic launch(input logic dir, input logic [31:0] base, input logic [BUF_AW:0] len,
                         input int done_off, input logic exp_err, input bit push_done);
      done_t d;
      @(posedge clk); #1;
      start = 1'b1; cfg_dir = dir; cfg_base = base; cfg_len = len;
      if (push_done) begin
         d.err = exp_err;
         d.cyc = (done_off < 0) ? -1 : cyc + done_off;
         exp_done_q.push_back(d);
      end
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_done(input int d0, input string name);
      for (int i = 0; i < 400 && done_cnt == d0; i++) @(posedge clk);
      n_chk++;
      if (done_cnt == d0) begin
         n_fail++;
         $display("FAIL %s: no done pulse within 400 cycles", name);
      end
   endtask

   task automatic set_slave(input int stall, input int dly, input int ew);
      cmd_stall = stall; rsp_delay = dly; err_word = ew;
      @(negedge clk); flush_req = 1'b1;
      @(negedge clk); flush_req = 1'b0;
   endtask

   // ICB slave: decisions sampled at negedge, applied just after the next rising edge.
   initial begin : slave
      bit hs, taken, pend;
      int dly, word, wait_cnt;
      icb_cmd_ready = 1'b0; icb_rsp_valid = 1'b0; icb_rsp_rdata = '0; icb_rsp_err = 1'b0;
      pend = 0; dly = 0; word = 0; wait_cnt = 0;
      forever begin
         @(negedge clk);
         hs    = icb_cmd_valid && icb_cmd_ready;
         taken = icb_rsp_valid && icb_rsp_ready;
         if (icb_cmd_valid && !icb_cmd_ready) wait_cnt++;
         @(posedge clk); #1;
         if (flush_req) begin
            pend = 0; dly = 0; word = 0; wait_cnt = 0;
            icb_rsp_valid = 1'b0; icb_rsp_rdata = '0; icb_rsp_err = 1'b0;
            icb_cmd_ready = (cmd_stall == 0);
         end else begin
            if (taken) begin
               icb_rsp_valid = 1'b0; icb_rsp_rdata = '0; icb_rsp_err = 1'b0;
            end
            if (hs) begin
               pend = 1; dly = rsp_delay; wait_cnt = 0;
            end else if (pend && dly > 0) begin
               dly--;
            end
            if (pend && dly == 0) begin
               icb_rsp_valid = 1'b1;
               icb_rsp_rdata = rd_data[word[2:0]];
               icb_rsp_err   = (word == err_word);
               word++;
               pend = 0;
            end
            icb_cmd_ready = (wait_cnt >= cmd_stall);
         end
      end
   end

   initial begin : bufmem
      bit en;
      logic [BUF_AW-1:0] a;
      buf_rd_data = '0;
      forever begin
         @(negedge clk);
         en = buf_rd_en; a = buf_rd_addr;
         @(posedge clk); #1;
         if (en) buf_rd_data = mem[a[2:0]];
      end
   end

   always @(negedge clk) begin : mon
      cmd_t  c;
      wr_t   w;
      done_t d;
      bit    outstanding;
      if (rst) begin
         outstanding = 0;
      end else begin
         if (icb_cmd_valid) chk("no_cmd_while_outstanding", 32'(outstanding), 32'd0);
         if (icb_cmd_valid && !icb_cmd_ready && exp_cmd_q.size() != 0) begin
            chk("stall_addr", icb_cmd_addr, exp_cmd_q[0].addr);
            if (!exp_cmd_q[0].rd) chk("stall_wdata", icb_cmd_wdata, exp_cmd_q[0].wdata);
         end
         if (icb_cmd_valid && icb_cmd_ready) begin
            hs_cnt++;
            outstanding = 1;
            if (exp_cmd_q.size() == 0) begin
               n_chk++; n_fail++;
               $display("FAIL unexpected_cmd: got addr 0x%08h, want no command (cycle %0d)", icb_cmd_addr, cyc);
            end else begin
               c = exp_cmd_q.pop_front();
               chk("cmd_addr", icb_cmd_addr, c.addr);
               chk("cmd_read", 32'(icb_cmd_read), 32'(c.rd));
               chk("cmd_wmask", 32'(icb_cmd_wmask), 32'hF);
               if (!c.rd) chk("cmd_wdata", icb_cmd_wdata, c.wdata);
            end
         end
         if (icb_rsp_valid && icb_rsp_ready) outstanding = 0;
         if (buf_wr_en) begin
            if (exp_wr_q.size() == 0) begin
               n_chk++; n_fail++;
               $display("FAIL unexpected_buf_wr: got addr %0d, want no write (cycle %0d)", buf_wr_addr, cyc);
            end else begin
               w = exp_wr_q.pop_front();
               chk("buf_wr_addr", 32'(buf_wr_addr), w.addr);
               chk("buf_wr_data", buf_wr_data, w.data);
            end
         end
         if (done) begin
            done_cnt++;
            if (exp_done_q.size() == 0) begin
               n_chk++; n_fail++;
               $display("FAIL unexpected_done: got done=1, want 0 (cycle %0d)", cyc);
            end else begin
               d = exp_done_q.pop_front();
               chk("done_err", 32'(err), 32'(d.err));
               chk("done_busy", 32'(busy), 32'd0);
               if (d.cyc >= 0) chk("done_cycle", cyc, d.cyc);
            end
         end
      end
   end

   task automatic chk_all_zero(input string tag);
      chk({tag, "_busy"},      32'(busy), 32'd0);
      chk({tag, "_done"},      32'(done), 32'd0);
      chk({tag, "_err"},       32'(err), 32'd0);
      chk({tag, "_rd_en"},     32'(buf_rd_en), 32'd0);
      chk({tag, "_rd_addr"},   32'(buf_rd_addr), 32'd0);
      chk({tag, "_wr_en"},     32'(buf_wr_en), 32'd0);
      chk({tag, "_wr_data"},   buf_wr_data, 32'd0);
      chk({tag, "_cmd_valid"}, 32'(icb_cmd_valid), 32'd0);
      chk({tag, "_cmd_read"},  32'(icb_cmd_read), 32'd0);
      chk({tag, "_cmd_addr"},  icb_cmd_addr, 32'd0);
      chk({tag, "_cmd_wdata"}, icb_cmd_wdata, 32'd0);
      chk({tag, "_rsp_ready"}, 32'(icb_rsp_ready), 32'd0);
      chk({tag, "_wmask"},     32'(icb_cmd_wmask), 32'hF);
   endtask

   initial begin : watchdog
      #400000;
      $display("FAIL watchdog: simulation still running at time limit");
      $fatal(1, "time limit");
   end

   initial begin : stim
      int d0, h0;
      rst = 1'b1; start = 1'b0; cfg_dir = 1'b0; cfg_base = '0; cfg_len = '0;
      for (int i = 0; i < 8; i++) begin mem[i] = '0; rd_data[i] = '0; end
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk_all_zero("reset");
      @(posedge clk); #1;
      rst = 1'b0;

      // Read, zero-wait: 2 cycles/word, done 7 cycles after start.
      rd_data[0] = 32'hA0; rd_data[1] = 32'hA1; rd_data[2] = 32'hA2;
      set_slave(0, 0, -1);
      push_cmd(32'h1000_0000, 1'b1, '0);
      push_cmd(32'h1000_0004, 1'b1, '0);
      push_cmd(32'h1000_0008, 1'b1, '0);
      push_wr(0, 32'hA0); push_wr(1, 32'hA1); push_wr(2, 32'hA2);
      d0 = done_cnt;
      launch(1'b1, 32'h1000_0000, 14'd3, 7, 1'b0, 1'b1);
      @(negedge clk);
      chk("read_busy", 32'(busy), 32'd1);
      wait_done(d0, "read_done");

      // Write, zero-wait: 4 cycles/word, done one cycle after second response.
      mem[0] = 32'h1234; mem[1] = 32'h5678;
      set_slave(0, 0, -1);
      push_cmd(32'h2000_0010, 1'b0, 32'h1234);
      push_cmd(32'h2000_0014, 1'b0, 32'h5678);
      d0 = done_cnt;
      launch(1'b0, 32'h2000_0010, 14'd2, 9, 1'b0, 1'b1);
      wait_done(d0, "write_done");

      // Backpressure plus a start pulse during the stall that must be ignored.
      mem[0] = 32'hCAFE_0001; mem[1] = 32'hCAFE_0002;
      set_slave(5, 3, -1);
      push_cmd(32'h3000_0000, 1'b0, 32'hCAFE_0001);
      push_cmd(32'h3000_0004, 1'b0, 32'hCAFE_0002);
      d0 = done_cnt;
      launch(1'b0, 32'h3000_0003, 14'd2, 25, 1'b0, 1'b1);
      repeat (3) @(posedge clk);
      #1;
      start = 1'b1; cfg_dir = 1'b1; cfg_base = 32'hDEAD_0000; cfg_len = '0;
      @(posedge clk); #1;
      start = 1'b0;
      wait_done(d0, "backpressure_done");

      // Error response on word 1 of 4.
      rd_data[0] = 32'hE0; rd_data[1] = 32'hE1;
      set_slave(0, 0, 1);
      push_cmd(32'h4000_0000, 1'b1, '0);
      push_cmd(32'h4000_0004, 1'b1, '0);
      push_wr(0, 32'hE0);
      d0 = done_cnt;
      launch(1'b1, 32'h4000_0000, 14'd4, 5, 1'b1, 1'b1);
      wait_done(d0, "error_done");
      repeat (2) @(negedge clk);
      chk("err_sticky", 32'(err), 32'd1);

      // Zero length: done next cycle, no traffic, err cleared by start.
      set_slave(0, 0, -1);
      d0 = done_cnt;
      launch(1'b1, 32'h7000_0000, 14'd0, 1, 1'b0, 1'b1);
      wait_done(d0, "zero_len_done");

      // Reset during RSP of word 2 of 5.
      rd_data[0] = 32'hB0; rd_data[1] = 32'hB1; rd_data[2] = 32'hB2;
      set_slave(0, 3, -1);
      push_cmd(32'h5000_0000, 1'b1, '0);
      push_cmd(32'h5000_0004, 1'b1, '0);
      push_cmd(32'h5000_0008, 1'b1, '0);
      push_wr(0, 32'hB0); push_wr(1, 32'hB1);
      h0 = hs_cnt;
      launch(1'b1, 32'h5000_0000, 14'd5, 0, 1'b0, 1'b0);
      for (int i = 0; i < 200 && hs_cnt < h0 + 3; i++) @(posedge clk);
      n_chk++;
      if (hs_cnt < h0 + 3) begin
         n_fail++;
         $display("FAIL reset_test_third_cmd: got %0d commands, want 3", hs_cnt - h0);
      end
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk_all_zero("midreset");
      repeat (4) @(negedge clk);
      chk("stale_rsp_valid_present", 32'(icb_rsp_valid), 32'd1);
      chk("stale_rsp_not_taken", 32'(icb_rsp_ready), 32'd0);

      // Fresh transfer after reset restarts from idx 0.
      rd_data[0] = 32'hC0; rd_data[1] = 32'hC1;
      set_slave(0, 0, -1);
      push_cmd(32'h6000_0000, 1'b1, '0);
      push_cmd(32'h6000_0004, 1'b1, '0);
      push_wr(0, 32'hC0); push_wr(1, 32'hC1);
      d0 = done_cnt;
      launch(1'b1, 32'h6000_0000, 14'd2, 5, 1'b0, 1'b1);
      wait_done(d0, "post_reset_done");

      repeat (5) @(negedge clk);
      chk("left_cmds", exp_cmd_q.size(), 32'd0);
      chk("left_wrs", exp_wr_q.size(), 32'd0);
      chk("left_dones", exp_done_q.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
